// File: rtl/quadrature_decoder.sv
// quadrature_decoder: synchronises, debounces and decodes a quadrature encoder into inc/dec/error pulses.
// Define QDEC_DETENT_EN to emit one pulse per full detent (11 to 11) instead of one per edge.
module quadrature_decoder #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DEBOUNCE_BITWIDTH = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  output logic       increment,
  output logic       decrement,
  output logic       error,
  output logic [1:0] state
);
  localparam logic [DEBOUNCE_BITWIDTH-1:0] LIMIT = DEBOUNCE_BITWIDTH'(DEBOUNCE_CYCLES);
  logic [1:0] sync1, sync2, prev, pos_prev, pos_cur, diff;
  logic [DEBOUNCE_BITWIDTH-1:0] cnt [2];
  logic fwd, rev, bad, inc_n, dec_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {a_in, b_in};
      sync2 <= sync1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (sync2[i] == state[i]) cnt[i] <= '0;
        else if (cnt[i] == LIMIT) begin
          state[i] <= sync2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  // Gray position {a, a^b} turns the 00-01-11-10 cycle into a plain mod-4 count
  always_comb begin
    pos_prev = {prev[1], ^prev};
    pos_cur = {state[1], ^state};
    diff = pos_cur - pos_prev;
    fwd = diff == 2'd1;
    rev = diff == 2'd3;
    bad = diff == 2'd2;
  end
`ifdef QDEC_DETENT_EN
  logic signed [3:0] acc, sum;
  logic enter;
  always_comb begin
    enter = state == 2'b11 && prev != 2'b11;
    sum = acc + (fwd ? 4'sd1 : rev ? -4'sd1 : 4'sd0);
    inc_n = enter && !bad && sum == 4'sd4;
    dec_n = enter && !bad && sum == -4'sd4;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else acc <= (bad || enter) ? 4'sd0 : sum;
`else
  always_comb begin
    inc_n = fwd;
    dec_n = rev;
  end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= 2'b11;
      increment <= 1'b0;
      decrement <= 1'b0;
      error <= 1'b0;
    end else begin
      prev <= state;
      increment <= inc_n;
      decrement <= dec_n;
      error <= bad;
    end
endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: table vectors, corner sequences and random pin activity against a cycle model.
module tb_quadrature_decoder;
  localparam int D = 4;
`ifdef QDEC_DETENT_EN
  localparam bit DET = 1;
`else
  localparam bit DET = 0;
`endif
  typedef struct {
    logic a, b;
    int cycles, inc, dec, err;
    logic [1:0] st;
  } vec_t;
  logic clk = 0, rst = 1, a_in = 1, b_in = 1;
  logic increment, decrement, error;
  logic [1:0] state;
  int checks = 0, errors = 0, n_inc = 0, n_dec = 0, n_err = 0;
  logic [1:0] m_s1, m_s2, m_deb, m_prev;
  logic m_inc, m_dec, m_err;
  int m_acc;
  logic [1:0] hist[$];
  int posof[4] = '{0, 1, 3, 2};
  vec_t tbl[$];

  quadrature_decoder #(.DEBOUNCE_CYCLES(D), .DEBOUNCE_BITWIDTH(3)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .increment(increment), .decrement(decrement), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 2'b11; m_s2 = 2'b11; m_deb = 2'b11; m_prev = 2'b11;
    m_inc = 0; m_dec = 0; m_err = 0; m_acc = 0;
    hist.delete();
  endtask

  // Debounced channel flips once its synchronised value has disagreed for D+1 straight samples
  task automatic model_edge();
    int d, stp;
    bit all;
    d = (posof[m_deb] - posof[m_prev] + 4) % 4;
    stp = d == 1 ? 1 : d == 3 ? -1 : 0;
    m_err = d == 2;
    if (DET) begin
      m_inc = 0; m_dec = 0;
      if (m_err) m_acc = 0;
      else begin
        m_acc += stp;
        if (m_deb == 2'b11 && m_prev != 2'b11) begin
          m_inc = m_acc == 4;
          m_dec = m_acc == -4;
          m_acc = 0;
        end
      end
    end else begin
      m_inc = d == 1;
      m_dec = d == 3;
    end
    m_prev = m_deb;
    hist.push_back(m_s2);
    if (hist.size() > D + 1) void'(hist.pop_front());
    for (int c = 0; c < 2; c++)
      if (hist.size() == D + 1) begin
        all = 1;
        foreach (hist[k]) if (hist[k][c] == m_deb[c]) all = 0;
        if (all) m_deb[c] = hist[D][c];
      end
    m_s2 = m_s1;
    m_s1 = {a_in, b_in};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check("increment", increment, m_inc);
    check("decrement", decrement, m_dec);
    check("error", error, m_err);
    check("state", state, m_deb);
    n_inc += int'(increment);
    n_dec += int'(decrement);
    n_err += int'(error);
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    a_in = a; b_in = b;
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    n_inc = 0; n_dec = 0; n_err = 0;
  endtask

  initial begin
    int e;
    model_reset();
    repeat (2) tick();
    for (int i = 0; i < 6; i++) hold(i[0], i[1], 2);
    check("rst_outputs", {increment, decrement, error}, 0);
    check("rst_state", state, 2'b11);
    check("rst_pulses", n_inc + n_dec + n_err, 0);
    a_in = 1; b_in = 1;
    rst = 0;
    hold(1, 1, 10);

    tbl.push_back('{1, 0, 20, DET ? 0 : 1, 0, 0, 2'b10});
    tbl.push_back('{0, 0, 20, DET ? 0 : 1, 0, 0, 2'b00});
    tbl.push_back('{0, 1, 20, DET ? 0 : 1, 0, 0, 2'b01});
    tbl.push_back('{1, 1, 20, 1, 0, 0, 2'b11});
    tbl.push_back('{0, 1, 20, 0, DET ? 0 : 1, 0, 2'b01});
    tbl.push_back('{0, 0, 20, 0, DET ? 0 : 1, 0, 2'b00});
    tbl.push_back('{1, 0, 20, 0, DET ? 0 : 1, 0, 2'b10});
    tbl.push_back('{1, 1, 20, 0, 1, 0, 2'b11});
    tbl.push_back('{0, 0, 20, 0, 0, 1, 2'b00});
    tbl.push_back('{0, 1, 20, DET ? 0 : 1, 0, 0, 2'b01});
    tbl.push_back('{1, 1, 20, DET ? 0 : 1, 0, 0, 2'b11});
    tbl.push_back('{1, 0, 20, DET ? 0 : 1, 0, 0, 2'b10});
    tbl.push_back('{0, 0, 20, DET ? 0 : 1, 0, 0, 2'b00});
    tbl.push_back('{1, 0, 20, 0, DET ? 0 : 1, 0, 2'b10});
    tbl.push_back('{1, 1, 20, 0, DET ? 0 : 1, 0, 2'b11});
    foreach (tbl[i]) begin
      clear_counts();
      hold(tbl[i].a, tbl[i].b, tbl[i].cycles);
      check($sformatf("vec%0d_inc", i), n_inc, tbl[i].inc);
      check($sformatf("vec%0d_dec", i), n_dec, tbl[i].dec);
      check($sformatf("vec%0d_err", i), n_err, tbl[i].err);
      check($sformatf("vec%0d_state", i), state, tbl[i].st);
    end

    // pin change to pulse latency: first edge is edge 0, pulse visible after edge D+3
    a_in = 0; b_in = 0;
    e = -1;
    do begin tick(); e++; end while (!error && e < 50);
    check("latency", e, D + 3);
    hold(0, 0, 10);
    hold(1, 1, 20);

    clear_counts();
    repeat (3) begin hold(0, 1, 3); hold(1, 1, 10); end
    check("glitch_pulses", n_inc + n_dec + n_err, 0);
    check("glitch_state", state, 2'b11);

    clear_counts();
    hold(0, 1, 3);
    rst = 1;
    a_in = 1;
    repeat (3) tick();
    rst = 0;
    hold(1, 1, 20);
    check("midrst_pulses", n_inc + n_dec + n_err, 0);
    check("midrst_state", state, 2'b11);

    clear_counts();
    repeat (10) begin
      hold(1, 0, D + 1); hold(0, 0, D + 1); hold(0, 1, D + 1); hold(1, 1, D + 1);
    end
    hold(1, 1, 20);
    check("maxrate_inc", n_inc, DET ? 10 : 40);
    check("maxrate_dec", n_dec, 0);
    check("maxrate_err", n_err, 0);

    repeat (300) hold(1'($urandom), 1'($urandom), $urandom_range(1, 12));
    hold(1, 1, 20);
    check("final_state", state, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
